hazard_ctrl: RTL and testbench

Hazard and sequencing controller for the 5-stage pipelined RISC-V datapath.
- Generates the operand-forwarding selects, the stage stall enables and the stage flush signals.
- Freezes the pipeline while a data-memory access in M is not ready.
- Enters a sticky error state if memory never responds.
- Keeps saturating stall-cycle and flush-cycle performance counters.
- Sits beside the datapath: it takes register addresses and control bits from the D/E/M/W stage registers and drives their en/reset inputs and the forward muxes.

---
 rtl/hazard_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Hazard and sequencing controller for a 5-stage pipelined RISC-V datapath.
// Sits beside the datapath: reads register addresses and control bits from the
// D/E/M/W stage registers and drives their enable/clear inputs plus the E-stage
// operand forward muxes.
//
//   - Operand forwarding selects for srcA/srcB in E (M has priority over W,
//     x0 is never forwarded).
//   - Load-use stall of F/D with a bubble into E.
//   - Branch/jump flush of D and E.
//   - Whole-pipeline freeze (F/D/E/M held, bubble into W) while a data-memory
//     access in M is not ready.
//   - Sticky error state when memory does not respond within MEM_TIMEOUT
//     consecutive waiting cycles; only reset leaves it.
//   - Saturating performance counters for StallF and FlushE cycles.
//
// Parameters
//   MEM_TIMEOUT  consecutive not-ready cycles in WAIT before ERR (1..255)
//   CNT_W        width of the performance counters
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   Rs1D, Rs2D                 source registers of the instruction in D
//   Rs1E, Rs2E, RdE            source/destination registers in E
//   RdM, RegWriteM             destination / write enable in M
//   RdW, RegWriteW             destination / write enable in W
//   ResultSrcE                 result select in E (2'b01 = load)
//   PCSrcE                     branch taken or jump in E
//   MemReqM, MemReadyM         data-memory request in M / completion this cycle
//   ForwardAE, ForwardBE       00 rd1E/rd2E, 01 ResultW, 10 ALUResultM
//   StallF/D/E/M               hold the respective stage
//   FlushD, FlushE             clear the respective stage register
//   FlushW                     bubble into W
//   MemErr                     sticky memory-timeout flag
//   StallCycles, FlushCycles   saturating counts of StallF / FlushE cycles
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic [1:0]       ResultSrcE,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushCycles
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_ERR  = 2'b10
  } state_e;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  // Forward-select encodings
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  state_e           state_q;
  logic [7:0]       tcnt_q;
  logic             mem_err_q;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic             lw_stall;
  logic             mem_stall;
  logic             freeze;

  // ---------------------------------------------------------------------------
  // Forwarding: newest producer (M) wins over the older one (W); x0 never
  // forwards because it reads as zero regardless of writes.
  // ---------------------------------------------------------------------------
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic       wr_m,
    input logic [4:0] rd_m,
    input logic       wr_w,
    input logic [4:0] rd_w
  );
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      return FWD_M;
    end else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      return FWD_W;
    end
    return FWD_RF;
  endfunction

  // ---------------------------------------------------------------------------
  // Hazard terms
  // ---------------------------------------------------------------------------
  assign lw_stall  = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                     ((RdE == Rs1D) || (RdE == Rs2D));

  // A not-ready access freezes the pipe only in IDLE/WAIT; ERR freezes anyway.
  // The ready cycle itself is a normal cycle because MemReadyM kills the term.
  assign mem_stall = (state_q != S_ERR) && MemReqM && !MemReadyM;
  assign freeze    = (state_q == S_ERR) || mem_stall;

  // ---------------------------------------------------------------------------
  // Output decode, in priority order: reset, freeze, normal operation.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned
    // and no latch is inferred.
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;

    if (reset) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else begin
      ForwardAE = fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
      ForwardBE = fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);
      if (freeze) begin
        // Pending branch/load-use effects are deferred: D and E stay intact
        // so the hazard is re-evaluated once memory completes.
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else begin
        StallF = lw_stall;
        StallD = lw_stall;
        FlushD = PCSrcE;
        FlushE = lw_stall | PCSrcE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Memory-wait FSM with timeout. tcnt_q counts consecutive not-ready cycles,
  // including the IDLE cycle that started the wait.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples values from before the edge.
    if (reset) begin
      state_q   <= S_IDLE;
      tcnt_q    <= 8'd0;
      mem_err_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (MemReqM && !MemReadyM) begin
            state_q <= S_WAIT;
            tcnt_q  <= 8'd1;
          end
        end
        S_WAIT: begin
          if (MemReadyM) begin
            state_q <= S_IDLE;
            tcnt_q  <= 8'd0;
          end else if (tcnt_q == TIMEOUT) begin
            state_q   <= S_ERR;
            mem_err_q <= 1'b1;
          end else begin
            tcnt_q <= tcnt_q + 8'd1;
          end
        end
        S_ERR: begin
          state_q <= S_ERR;
        end
        default: begin
          state_q <= S_IDLE;
          tcnt_q  <= 8'd0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating performance counters
  // ---------------------------------------------------------------------------
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (StallF && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (FlushE && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign MemErr      = mem_err_q;
  assign StallCycles = stall_cnt_q;
  assign FlushCycles = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Directed scenarios for forwarding, load-use, branch flush, memory wait,
// timeout/error, reset and counter saturation, followed by a randomized run.
// Every cycle the DUT outputs are compared with a behavioural model that keeps
// only the abstract memory status (error flag, whether a wait is in progress,
// length of the current not-ready run) and the two counter values.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam int T    = 4;             // MEM_TIMEOUT used for this bench
  localparam int W    = 4;             // CNT_W used for this bench
  localparam int CMAX = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset;
  logic [4:0]   Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic         RegWriteM, RegWriteW;
  logic [1:0]   ResultSrcE;
  logic         PCSrcE, MemReqM, MemReadyM;
  logic [1:0]   ForwardAE, ForwardBE;
  logic         StallF, StallD, StallE, StallM;
  logic         FlushD, FlushE, FlushW, MemErr;
  logic [W-1:0] StallCycles, FlushCycles;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  bit m_err;
  bit m_waiting;
  int m_run;
  int m_stall_cnt;
  int m_flush_cnt;

  // Expected combinational outputs for the current cycle
  logic [1:0] e_fa, e_fb;
  logic       e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_fw;

  hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .Rs1D       (Rs1D),
    .Rs2D       (Rs2D),
    .Rs1E       (Rs1E),
    .Rs2E       (Rs2E),
    .RdE        (RdE),
    .RdM        (RdM),
    .RdW        (RdW),
    .RegWriteM  (RegWriteM),
    .RegWriteW  (RegWriteW),
    .ResultSrcE (ResultSrcE),
    .PCSrcE     (PCSrcE),
    .MemReqM    (MemReqM),
    .MemReadyM  (MemReadyM),
    .ForwardAE  (ForwardAE),
    .ForwardBE  (ForwardBE),
    .StallF     (StallF),
    .StallD     (StallD),
    .StallE     (StallE),
    .StallM     (StallM),
    .FlushD     (FlushD),
    .FlushE     (FlushE),
    .FlushW     (FlushW),
    .MemErr     (MemErr),
    .StallCycles(StallCycles),
    .FlushCycles(FlushCycles)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_outputs();
    bit lw, ms;
    lw = (ResultSrcE == 2'b01) && (RdE != 0) && (RdE == Rs1D || RdE == Rs2D);
    ms = !m_err && MemReqM && !MemReadyM;
    {e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_fw} = '0;
    e_fa = 2'b00;
    e_fb = 2'b00;
    if (reset) begin
      e_fd = 1'b1;
      e_fe = 1'b1;
    end else begin
      e_fa = exp_fwd(Rs1E);
      e_fb = exp_fwd(Rs2E);
      if (m_err || ms) begin
        {e_sf, e_sd, e_se, e_sm, e_fw} = 5'b11111;
      end else begin
        e_sf = lw;
        e_sd = lw;
        e_fd = PCSrcE;
        e_fe = lw | PCSrcE;
      end
    end
  endtask

  task automatic model_step();
    if (reset) begin
      m_err       = 1'b0;
      m_waiting   = 1'b0;
      m_run       = 0;
      m_stall_cnt = 0;
      m_flush_cnt = 0;
    end else begin
      if (e_sf && m_stall_cnt < CMAX) m_stall_cnt++;
      if (e_fe && m_flush_cnt < CMAX) m_flush_cnt++;
      if (!m_err) begin
        if (!m_waiting) begin
          if (MemReqM && !MemReadyM) begin
            m_waiting = 1'b1;
            m_run     = 1;
          end
        end else if (MemReadyM) begin
          m_waiting = 1'b0;
          m_run     = 0;
        end else if (m_run >= T) begin
          m_err = 1'b1;
        end else begin
          m_run++;
        end
      end
    end
  endtask

  // One clock cycle: compare combinational outputs mid-cycle, advance the
  // model with the edge, then compare registered outputs just after it.
  task automatic cycle();
    @(negedge clk);
    model_outputs();
    check("ForwardAE",  32'(ForwardAE), 32'(e_fa));
    check("ForwardBE",  32'(ForwardBE), 32'(e_fb));
    check("StallF",     32'(StallF),    32'(e_sf));
    check("StallD",     32'(StallD),    32'(e_sd));
    check("StallE",     32'(StallE),    32'(e_se));
    check("StallM",     32'(StallM),    32'(e_sm));
    check("FlushD",     32'(FlushD),    32'(e_fd));
    check("FlushE",     32'(FlushE),    32'(e_fe));
    check("FlushW",     32'(FlushW),    32'(e_fw));
    @(posedge clk);
    model_step();
    #1;
    check("MemErr",      32'(MemErr),      32'(m_err));
    check("StallCycles", 32'(StallCycles), 32'(m_stall_cnt));
    check("FlushCycles", 32'(FlushCycles), 32'(m_flush_cnt));
  endtask

  task automatic idle_inputs();
    Rs1D = 5'd1; Rs2D = 5'd2; Rs1E = 5'd3; Rs2E = 5'd4;
    RdE = 5'd0; RdM = 5'd0; RdW = 5'd0;
    RegWriteM = 1'b0; RegWriteW = 1'b0;
    ResultSrcE = 2'b00; PCSrcE = 1'b0;
    MemReqM = 1'b0; MemReadyM = 1'b1;
  endtask

  task automatic check_freeze(input string tag);
    check({tag, "_StallF"}, 32'(StallF), 32'd1);
    check({tag, "_StallM"}, 32'(StallM), 32'd1);
    check({tag, "_FlushW"}, 32'(FlushW), 32'd1);
    check({tag, "_FlushD"}, 32'(FlushD), 32'd0);
  endtask

  initial begin
    m_err = 0; m_waiting = 0; m_run = 0; m_stall_cnt = 0; m_flush_cnt = 0;

    // ---- Reset: hazards present but outputs forced ----
    idle_inputs();
    reset = 1'b1;
    RegWriteM = 1'b1; RdM = 5'd3; ResultSrcE = 2'b01; RdE = 5'd1;
    #1;
    check("rst_ForwardAE", 32'(ForwardAE), 32'd0);
    check("rst_StallF",    32'(StallF),    32'd0);
    check("rst_FlushD",    32'(FlushD),    32'd1);
    check("rst_FlushE",    32'(FlushE),    32'd1);
    check("rst_FlushW",    32'(FlushW),    32'd0);
    cycle();
    cycle();
    check("rst_MemErr",      32'(MemErr),      32'd0);
    check("rst_StallCycles", 32'(StallCycles), 32'd0);
    check("rst_FlushCycles", 32'(FlushCycles), 32'd0);

    // ---- Forwarding: M priority, then W, then none ----
    idle_inputs();
    reset = 1'b0;
    RegWriteM = 1'b1; RdM = 5'd5; RegWriteW = 1'b1; RdW = 5'd5;
    Rs1E = 5'd5; Rs2E = 5'd5;
    #1;
    check("fwdM_A", 32'(ForwardAE), 32'd2);
    check("fwdM_B", 32'(ForwardBE), 32'd2);
    cycle();
    RdM = 5'd0;
    #1;
    check("fwdW_A", 32'(ForwardAE), 32'd1);
    check("fwdW_B", 32'(ForwardBE), 32'd1);
    cycle();
    RdW = 5'd0;
    #1;
    check("fwd0_A", 32'(ForwardAE), 32'd0);
    check("fwd0_B", 32'(ForwardBE), 32'd0);
    cycle();

    // ---- Load-use ----
    idle_inputs();
    ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
    #1;
    check("lw_StallF", 32'(StallF), 32'd1);
    check("lw_StallD", 32'(StallD), 32'd1);
    check("lw_FlushE", 32'(FlushE), 32'd1);
    check("lw_FlushD", 32'(FlushD), 32'd0);
    check("lw_StallE", 32'(StallE), 32'd0);
    cycle();
    ResultSrcE = 2'b00;
    #1;
    check("lw_next_StallF", 32'(StallF), 32'd0);
    check("lw_next_FlushE", 32'(FlushE), 32'd0);
    cycle();
    check("lw_StallCycles", 32'(StallCycles), 32'd1);
    check("lw_FlushCycles", 32'(FlushCycles), 32'd1);

    // ---- Taken branch, alone and with load-use ----
    idle_inputs();
    PCSrcE = 1'b1;
    #1;
    check("br_FlushD", 32'(FlushD), 32'd1);
    check("br_FlushE", 32'(FlushE), 32'd1);
    check("br_StallF", 32'(StallF), 32'd0);
    cycle();
    ResultSrcE = 2'b01; RdE = 5'd9; Rs1D = 5'd9;
    #1;
    check("brlw_StallF", 32'(StallF), 32'd1);
    check("brlw_StallD", 32'(StallD), 32'd1);
    check("brlw_FlushD", 32'(FlushD), 32'd1);
    check("brlw_FlushE", 32'(FlushE), 32'd1);
    cycle();
    check("br_StallCycles", 32'(StallCycles), 32'd2);
    check("br_FlushCycles", 32'(FlushCycles), 32'd3);

    // ---- Memory wait: 3 not-ready cycles with a pending branch ----
    idle_inputs();
    PCSrcE = 1'b1; MemReqM = 1'b1; MemReadyM = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_freeze("wait");
      check("wait_StallE", 32'(StallE), 32'd1);
      cycle();
    end
    MemReadyM = 1'b1;
    #1;
    check("ready_StallF", 32'(StallF), 32'd0);
    check("ready_FlushW", 32'(FlushW), 32'd0);
    check("ready_FlushD", 32'(FlushD), 32'd1);
    cycle();
    check("wait_StallCycles", 32'(StallCycles), 32'd5);
    check("wait_FlushCycles", 32'(FlushCycles), 32'd4);
    check("wait_MemErr",      32'(MemErr),      32'd0);

    // ---- Timeout: 5 not-ready cycles reach ERR ----
    idle_inputs();
    MemReqM = 1'b1; MemReadyM = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_freeze("tmo");
      cycle();
      check("tmo_MemErr", 32'(MemErr), (i == 4) ? 32'd1 : 32'd0);
    end
    MemReadyM = 1'b1;
    #1;
    check_freeze("err");
    cycle();
    check("err_StallCycles", 32'(StallCycles), 32'd11);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    MemReqM = 1'b0;
    #1;
    check("post_rst_MemErr",      32'(MemErr),      32'd0);
    check("post_rst_StallCycles", 32'(StallCycles), 32'd0);
    check("post_rst_FlushCycles", 32'(FlushCycles), 32'd0);
    check("post_rst_StallF",      32'(StallF),      32'd0);
    cycle();

    // ---- Counter saturation ----
    idle_inputs();
    ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
    for (int i = 0; i < 20; i++) cycle();
    check("sat_StallCycles", 32'(StallCycles), 32'd15);
    check("sat_FlushCycles", 32'(FlushCycles), 32'd15);

    // ---- Randomized run against the model ----
    reset = 1'b1;
    cycle();
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 63) == 0);
      Rs1D       = 5'($urandom_range(0, 3));
      Rs2D       = 5'($urandom_range(0, 3));
      Rs1E       = 5'($urandom_range(0, 3));
      Rs2E       = 5'($urandom_range(0, 3));
      RdE        = 5'($urandom_range(0, 3));
      RdM        = 5'($urandom_range(0, 3));
      RdW        = 5'($urandom_range(0, 3));
      RegWriteM  = 1'($urandom_range(0, 1));
      RegWriteW  = 1'($urandom_range(0, 1));
      ResultSrcE = 2'($urandom_range(0, 3));
      PCSrcE     = ($urandom_range(0, 3) == 0);
      MemReqM    = 1'($urandom_range(0, 1));
      MemReadyM  = ($urandom_range(0, 2) != 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
